// File: rtl/noc_pkg.sv
// Shared definitions for the 3x3 mesh router: port codes, flit field
// positions, mesh limits, requester FSM states and the XY route function.
package noc_pkg;

  // Port codes, also used as arbiter grant codes
  localparam logic [2:0] PORT_N    = 3'd0;
  localparam logic [2:0] PORT_E    = 3'd1;
  localparam logic [2:0] PORT_S    = 3'd2;
  localparam logic [2:0] PORT_W    = 3'd3;
  localparam logic [2:0] PORT_PE   = 3'd4;
  localparam logic [2:0] PORT_NONE = 3'd5;

  // Destination fields, counted down from the flit MSB
  localparam int COORD_W = 2;
  localparam int DX_HI   = 0;
  localparam int DY_HI   = 2;

  // Largest legal coordinate; coordinate 3 marks an undeliverable flit
  localparam logic [COORD_W-1:0] MESH_MAX = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } ipr_state_t;

  // Dimension-ordered routing: resolve X first, then Y, then deliver locally
  function automatic logic [2:0] xy_route(
    input logic [COORD_W-1:0] dx,
    input logic [COORD_W-1:0] dy,
    input logic [COORD_W-1:0] x_id,
    input logic [COORD_W-1:0] y_id
  );
    if (dx > x_id)      return PORT_E;
    else if (dx < x_id) return PORT_W;
    else if (dy > y_id) return PORT_S;
    else if (dy < y_id) return PORT_N;
    else                return PORT_PE;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head so the requester can
// route and forward the oldest flit without an extra read cycle.
module sync_fifo #(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [FLIT_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [FLIT_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic              do_push;
  logic              do_pop;

  // Full/empty come from the registered count only, so a pop never frees
  // room for a push in the same cycle.
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  // Storage write; contents need no reset because count guards every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/in_port_req.sv
// Requester side of one router input: buffers flits, raises a registered
// gate code towards the output arbiters and pops the head once granted.
// Optional starvation monitor enabled by defining IPR_STARVE_EN.
module in_port_req
  import noc_pkg::*;
#(
  parameter int         FLIT_W  = 16,
  parameter int         DEPTH   = 4,
  parameter int         X_ID    = 0,
  parameter int         Y_ID    = 0,
  parameter logic [2:0] MY_PORT = 3'd4
`ifdef IPR_STARVE_EN
  , parameter int       STARVE_LIM = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              in_ready,
  output logic [2:0]        gate,
  input  logic [2:0]        grant_n,
  input  logic [2:0]        grant_e,
  input  logic [2:0]        grant_s,
  input  logic [2:0]        grant_w,
  input  logic [2:0]        grant_pe,
  input  logic [4:0]        dn_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  output logic              route_err
`ifdef IPR_STARVE_EN
  , output logic            starve
`endif
);

  localparam logic [COORD_W-1:0] X_C = COORD_W'(X_ID);
  localparam logic [COORD_W-1:0] Y_C = COORD_W'(Y_ID);

  ipr_state_t          state_reg, state_next;
  logic [2:0]          gate_reg, gate_next;
  logic                fifo_full, fifo_empty, fifo_pop;
  logic [FLIT_W-1:0]   head;
  logic [COORD_W-1:0]  dx, dy;
  logic                head_err;
  logic [2:0]          g_sel;
  logic                dn_sel;
  logic                granted;

  sync_fifo #(
    .DEPTH (DEPTH),
    .FLIT_W(FLIT_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (in_valid),
    .pop  (fifo_pop),
    .din  (in_flit),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (head)
  );

  assign in_ready = !fifo_full;
  assign out_flit = head;
  assign gate     = gate_reg;

  assign dx       = head[FLIT_W-1-DX_HI -: COORD_W];
  assign dy       = head[FLIT_W-1-DY_HI -: COORD_W];
  assign head_err = (dx > MESH_MAX) || (dy > MESH_MAX);

  // Pick the grant and downstream ready of the output we are requesting
  always_comb begin
    g_sel  = PORT_NONE;
    dn_sel = 1'b0;
    case (gate_reg)
      PORT_N:  begin g_sel = grant_n;  dn_sel = dn_ready[0]; end
      PORT_E:  begin g_sel = grant_e;  dn_sel = dn_ready[1]; end
      PORT_S:  begin g_sel = grant_s;  dn_sel = dn_ready[2]; end
      PORT_W:  begin g_sel = grant_w;  dn_sel = dn_ready[3]; end
      PORT_PE: begin g_sel = grant_pe; dn_sel = dn_ready[4]; end
      default: begin g_sel = PORT_NONE; dn_sel = 1'b0; end
    endcase
  end

  assign granted = (g_sel == MY_PORT) && dn_sel;

  // State and gate registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      gate_reg  <= PORT_NONE;
    end else begin
      state_reg <= state_next;
      gate_reg  <= gate_next;
    end
  end

  // Next state, gate code and pop/pulse outputs. HOLD lets the arbiter's
  // registered grant catch up with gate=NONE before a new request is made.
  always_comb begin
    state_next = state_reg;
    gate_next  = gate_reg;
    fifo_pop   = 1'b0;
    out_valid  = 1'b0;
    route_err  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        gate_next = PORT_NONE;
        if (!fifo_empty) begin
          if (head_err) begin
            fifo_pop  = 1'b1;
            route_err = 1'b1;
          end else begin
            state_next = ST_REQ;
            gate_next  = xy_route(dx, dy, X_C, Y_C);
          end
        end
      end
      ST_REQ: begin
        if (granted) begin
          fifo_pop   = 1'b1;
          out_valid  = 1'b1;
          state_next = ST_HOLD;
          gate_next  = PORT_NONE;
        end
      end
      ST_HOLD: begin
        state_next = ST_IDLE;
        gate_next  = PORT_NONE;
      end
      default: begin
        state_next = ST_IDLE;
        gate_next  = PORT_NONE;
      end
    endcase
  end

`ifdef IPR_STARVE_EN
  logic [15:0] starve_cnt_reg;

  // Counts cycles spent in REQ, including the current one; zero elsewhere
  always_ff @(posedge clk) begin
    if (rst || (state_next != ST_REQ)) begin
      starve_cnt_reg <= '0;
    end else if (starve_cnt_reg != 16'hFFFF) begin
      starve_cnt_reg <= starve_cnt_reg + 16'd1;
    end
  end

  assign starve = (starve_cnt_reg >= 16'(STARVE_LIM));
`endif

endmodule

// File: tb/tb_in_port_req.sv
// Directed testbench for in_port_req: routing, grant handshake, FIFO fill,
// downstream backpressure, error drop, mid-operation reset and (when
// IPR_STARVE_EN is defined) the starvation flag.
module tb_in_port_req;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid2;
  logic [15:0] in_flit;
  logic        in_ready, in_ready2;
  logic [2:0]  gate, gate2;
  logic [2:0]  grant_n, grant_e, grant_s, grant_w, grant_pe;
  logic [4:0]  dn_ready;
  logic [15:0] out_flit, out_flit2;
  logic        out_valid, out_valid2;
  logic        route_err, route_err2;
`ifdef IPR_STARVE_EN
  logic        starve, starve2;
`endif

  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  in_port_req #(
    .FLIT_W(16), .DEPTH(4), .X_ID(0), .Y_ID(0), .MY_PORT(3'd4)
`ifdef IPR_STARVE_EN
    , .STARVE_LIM(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit),
    .in_ready(in_ready), .gate(gate),
    .grant_n(grant_n), .grant_e(grant_e), .grant_s(grant_s),
    .grant_w(grant_w), .grant_pe(grant_pe), .dn_ready(dn_ready),
    .out_flit(out_flit), .out_valid(out_valid), .route_err(route_err)
`ifdef IPR_STARVE_EN
    , .starve(starve)
`endif
  );

  in_port_req #(
    .FLIT_W(16), .DEPTH(4), .X_ID(1), .Y_ID(1), .MY_PORT(3'd4)
`ifdef IPR_STARVE_EN
    , .STARVE_LIM(4)
`endif
  ) dut11 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_flit(in_flit),
    .in_ready(in_ready2), .gate(gate2),
    .grant_n(grant_n), .grant_e(grant_e), .grant_s(grant_s),
    .grant_w(grant_w), .grant_pe(grant_pe), .dn_ready(dn_ready),
    .out_flit(out_flit2), .out_valid(out_valid2), .route_err(route_err2)
`ifdef IPR_STARVE_EN
    , .starve(starve2)
`endif
  );

  function automatic logic [15:0] mk(input logic [1:0] x, input logic [1:0] y,
                                     input logic [11:0] p);
    return {x, y, p};
  endfunction

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_grant(input logic [2:0] g);
    grant_n = g; grant_e = g; grant_s = g; grant_w = g; grant_pe = g;
  endtask

  task automatic push_a(input logic [15:0] f);
    in_valid = 1'b1; in_flit = f;
    tick();
    in_valid = 1'b0;
  endtask

  // Grant everything for a while to empty both instances
  task automatic settle();
    set_grant(3'd4);
    dn_ready = 5'h1F;
    repeat (10) tick();
    set_grant(3'd5);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tests_run++;
    if (gate !== 3'd5 || in_ready !== 1'b1 || out_valid !== 1'b0 || route_err !== 1'b0) begin
      failures++;
      $display("FAIL reset: gate=%0d in_ready=%b out_valid=%b route_err=%b, want 5 1 0 0",
               gate, in_ready, out_valid, route_err);
    end
`ifdef IPR_STARVE_EN
    tests_run++;
    if (starve !== 1'b0) begin
      failures++;
      $display("FAIL reset_starve: got %b want 0", starve);
    end
`endif
    $display("[TB] reset done");
  endtask

  task automatic test_basic();
    logic [15:0] f;
    f = mk(2'd2, 2'd1, 12'h0A5);
    dn_ready = 5'h1F;
    set_grant(3'd5);
    push_a(f);
    tests_run++;
    if (gate !== 3'd5) begin
      failures++; $display("FAIL basic_idle_gate: got %0d want 5", gate);
    end
    tick();
    tests_run++;
    if (gate !== 3'd1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_req1: gate=%0d out_valid=%b want 1 0", gate, out_valid);
    end
    tick();
    grant_e = 3'd4;
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_flit !== f) begin
      failures++;
      $display("FAIL basic_pop: out_valid=%b flit=%h want 1 %h", out_valid, out_flit, f);
    end
    tick();
    tests_run++;
    if (gate !== 3'd5 || out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_hold: gate=%0d out_valid=%b want 5 0", gate, out_valid);
    end
    tick();
    tests_run++;
    if (gate !== 3'd5 || out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_after: gate=%0d out_valid=%b want 5 0", gate, out_valid);
    end
    set_grant(3'd5);
    $display("[TB] basic: flit %h popped toward E", f);
  endtask

  task automatic test_route();
    set_grant(3'd5);
    push_a(mk(2'd0, 2'd0, 12'h111));
    tick();
    tests_run++;
    if (gate !== 3'd4) begin
      failures++; $display("FAIL route_pe: got %0d want 4", gate);
    end
    settle();
    push_a(mk(2'd0, 2'd2, 12'h222));
    tick();
    tests_run++;
    if (gate !== 3'd2) begin
      failures++; $display("FAIL route_s: got %0d want 2", gate);
    end
    settle();
    in_valid2 = 1'b1; in_flit = mk(2'd1, 2'd0, 12'h333);
    tick();
    in_valid2 = 1'b0;
    tick();
    tests_run++;
    if (gate2 !== 3'd0) begin
      failures++; $display("FAIL route_n: got %0d want 0", gate2);
    end
    settle();
    $display("[TB] route: PE/S/N cases done");
  endtask

  task automatic test_route_err();
    int pops;
    set_grant(3'd4);
    dn_ready = 5'h1F;
    pops = 0;
    push_a(mk(2'd3, 2'd0, 12'h444));
    tests_run++;
    if (route_err !== 1'b1 || gate !== 3'd5 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse: route_err=%b gate=%0d out_valid=%b want 1 5 0",
               route_err, gate, out_valid);
    end
    tick();
    tests_run++;
    if (route_err !== 1'b0) begin
      failures++; $display("FAIL err_once: route_err=%b want 0", route_err);
    end
    for (int i = 0; i < 4; i++) begin
      if (out_valid) pops++;
      tick();
    end
    tests_run++;
    if (gate !== 3'd5 || pops != 0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL err_drop: gate=%0d pops=%0d in_ready=%b want 5 0 1", gate, pops, in_ready);
    end
    set_grant(3'd5);
    $display("[TB] route_err: dest x=3 dropped");
  endtask

  task automatic test_fill();
    logic [15:0] exp_q [4];
    int k;
    set_grant(3'd5);
    dn_ready = 5'h1F;
    for (int i = 0; i < 4; i++) exp_q[i] = mk(2'd1, 2'd0, 12'(16 + i));
    for (int i = 0; i < 4; i++) push_a(exp_q[i]);
    tests_run++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL fill_full: in_ready=%b want 0", in_ready);
    end
    push_a(mk(2'd1, 2'd0, 12'hFFF));
    tests_run++;
    if (in_ready !== 1'b0 || gate !== 3'd1) begin
      failures++; $display("FAIL fill_hold: in_ready=%b gate=%0d want 0 1", in_ready, gate);
    end
    set_grant(3'd4);
    #1;
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      if (out_valid) begin
        tests_run++;
        if (out_flit !== exp_q[k]) begin
          failures++; $display("FAIL fill_pop%0d: got %h want %h", k, out_flit, exp_q[k]);
        end
        $display("[TB] fill: pop %0d flit=%h", k, out_flit);
        k++;
        tick();
        tests_run++;
        if (gate !== 3'd5 || out_valid !== 1'b0) begin
          failures++;
          $display("FAIL fill_hold%0d: gate=%0d out_valid=%b want 5 0", k, gate, out_valid);
        end
      end else begin
        tick();
      end
    end
    tests_run++;
    if (k != 4) begin
      failures++; $display("FAIL fill_count: got %0d pops want 4", k);
    end
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) k++;
      tick();
    end
    tests_run++;
    if (k != 0 || gate !== 3'd5 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL fill_5th_dropped: extra pops=%0d gate=%0d in_ready=%b want 0 5 1",
               k, gate, in_ready);
    end
    set_grant(3'd5);
  endtask

  task automatic test_backpressure();
    int pops;
    logic [15:0] f;
    f = mk(2'd2, 2'd2, 12'h5A5);
    set_grant(3'd4);
    dn_ready = 5'h1D;
    push_a(f);
    tick();
    pops = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) pops++;
      tick();
    end
    tests_run++;
    if (pops != 0 || gate !== 3'd1) begin
      failures++; $display("FAIL bp_stall: pops=%0d gate=%0d want 0 1", pops, gate);
    end
    dn_ready = 5'h1F;
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_flit !== f) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b flit=%h want 1 %h", out_valid, out_flit, f);
    end
    tick();
    pops = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) pops++;
      tick();
    end
    tests_run++;
    if (pops != 0) begin
      failures++; $display("FAIL bp_single: extra pops=%0d want 0", pops);
    end
    set_grant(3'd5);
    $display("[TB] backpressure: flit %h popped after release", f);
  endtask

  task automatic test_mid_reset();
    int pops;
    set_grant(3'd5);
    dn_ready = 5'h1F;
    push_a(mk(2'd1, 2'd1, 12'h0C1));
    push_a(mk(2'd1, 2'd1, 12'h0C2));
    tests_run++;
    if (gate !== 3'd1) begin
      failures++; $display("FAIL mrst_req: gate=%0d want 1", gate);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (gate !== 3'd5 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mrst_out: gate=%0d in_ready=%b out_valid=%b want 5 1 0",
               gate, in_ready, out_valid);
    end
    set_grant(3'd4);
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (out_valid) pops++;
      tick();
    end
    tests_run++;
    if (pops != 0 || gate !== 3'd5) begin
      failures++; $display("FAIL mrst_flush: pops=%0d gate=%0d want 0 5", pops, gate);
    end
    set_grant(3'd5);
    $display("[TB] mid_reset: queue discarded");
  endtask

`ifdef IPR_STARVE_EN
  task automatic test_starve();
    logic [3:0] seen;
    set_grant(3'd5);
    dn_ready = 5'h1F;
    push_a(mk(2'd2, 2'd0, 12'h0D0));
    tick();
    seen = '0;
    for (int i = 0; i < 4; i++) begin
      seen[i] = starve;
      if (i < 3) tick();
    end
    tests_run++;
    if (seen !== 4'b1000 || gate !== 3'd1) begin
      failures++; $display("FAIL starve_onset: seq=%b gate=%0d want 1000 1", seen, gate);
    end
    set_grant(3'd4);
    tick();
    tests_run++;
    if (starve !== 1'b0 || gate !== 3'd5) begin
      failures++; $display("FAIL starve_clear: starve=%b gate=%0d want 0 5", starve, gate);
    end
    settle();
    $display("[TB] starve: asserted on 4th REQ cycle");
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; in_flit = '0;
    dn_ready = 5'h1F;
    set_grant(3'd5);
    test_reset();
    test_basic();
    test_route();
    test_route_err();
    test_fill();
    test_backpressure();
    test_mid_reset();
`ifdef IPR_STARVE_EN
    test_starve();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
